// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             tx_n, busy_n, done_n;
  logic             last;
`ifdef SERIAL_TX_PARITY_EN
  logic             par, par_n;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      timer  <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      tx     <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      tx     <= tx_n;
      busy   <= busy_n;
      done   <= done_n;
`ifdef SERIAL_TX_PARITY_EN
      par    <= par_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
`ifdef SERIAL_TX_PARITY_EN
    par_n    = par;
`endif
    last = (timer == T_LAST);
    if (state != IDLE)
      timer_n = last ? '0 : timer + TW'(1);
    unique case (state)
      IDLE: begin
        if (load) begin
          state_n  = START;
          shreg_n  = data_in;
          timer_n  = '0;
          bitcnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
          par_n    = ^data_in;
`endif
        end
      end
      START: if (last) state_n = DATA;
      DATA: begin
        if (last) begin
          shreg_n = shreg >> 1;
          if (bitcnt == B_LAST) begin
            bitcnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_n  = PARITY;
`else
            state_n  = STOP;
`endif
          end else begin
            bitcnt_n = bitcnt + BW'(1);
          end
        end
      end
      PARITY: if (last) state_n = STOP;
      STOP: if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    tx_n   = 1'b1;
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (timer_n == T_LAST);
    unique case (state_n)
      START: tx_n = 1'b0;
      DATA:  tx_n = shreg_n[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed and random frames against a bit-list model.
// Works with or without SERIAL_TX_PARITY_EN defined.
module tb_serial_tx;

  localparam int C = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, busy, done;
  logic       load6 = 1'b0;
  logic [0:0] data6 = 1'b0;
  logic       tx6, busy6, done6;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .tx(tx), .busy(busy), .done(done)
  );

  serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut6 (
    .clk(clk), .reset(reset), .load(load6), .data_in(data6),
    .tx(tx6), .busy(busy6), .done(done6)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Line levels of one frame, one entry per bit period.
  function automatic bitq_t frame_bits(input logic [7:0] d, input int w);
    bitq_t q;
    bit p;
    p = 1'b0;
    q.push_back(1'b0);
    for (int k = 0; k < w; k++) begin
      q.push_back(d[k]);
      p = p ^ d[k];
    end
    if (PB == 1) q.push_back(p);
    q.push_back(1'b1);
    return q;
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_idle_tx"}, tx, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_done"}, done, 0);
  endtask

  task automatic start(input logic [7:0] d, input bit hold);
    load = 1'b1;
    data_in = d;
    cyc();
    load = hold;
  endtask

  // Check a frame already accepted; optionally inject a load, hold load, or stop early.
  task automatic frame(input logic [7:0] d, input bit hold,
                       input logic [7:0] nd, input int inj,
                       input int stop_at, input string tag);
    bitq_t b;
    int n;
    b = frame_bits(d, 8);
    n = b.size() * C;
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) return;
      chk({tag, "_tx"}, tx, b[i / C]);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done"}, done, (i == n - 1));
      if (hold) begin
        load = 1'b1;
        data_in = nd;
      end else begin
        load = (i == inj);
        data_in = (i == inj) ? 8'hFF : 8'($urandom);
      end
      cyc();
    end
    idle_chk(tag);
  endtask

  initial begin
    bitq_t q6;
    logic [7:0] rd;

    #2 reset = 1'b0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst6_tx", tx6, 1);
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    idle_chk("post_rst");

    start(8'hA5, 1'b0);
    frame(8'hA5, 1'b0, 8'h00, -1, -1, "a5");

    cyc();
    start(8'h00, 1'b0);
    frame(8'h00, 1'b0, 8'h00, 9, -1, "ign");
    repeat (3) begin
      cyc();
      idle_chk("no_second");
    end

    start(8'h01, 1'b1);
    frame(8'h01, 1'b1, 8'h80, -1, -1, "b2b1");
    cyc();
    load = 1'b0;
    frame(8'h80, 1'b0, 8'h00, -1, -1, "b2b2");

    cyc();
    start(8'h3C, 1'b0);
    frame(8'h3C, 1'b0, 8'h00, -1, 17, "abort_pre");
    #2 reset = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (8 * C) begin
      cyc();
      chk("abort_nodone", done, 0);
      chk("abort_nobusy", busy, 0);
    end
    reset = 1'b1;
    cyc();
    idle_chk("abort_rel");
    start(8'hC3, 1'b0);
    frame(8'hC3, 1'b0, 8'h00, -1, -1, "c3");

    repeat (4) begin
      rd = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin
        cyc();
        idle_chk("gap");
      end
      start(rd, 1'b0);
      frame(rd, 1'b0, 8'h00, -1, -1, "rand");
    end

    for (int t = 0; t < 2; t++) begin
      data6 = (t == 0) ? 1'b1 : 1'b0;
      q6 = frame_bits({7'b0, data6}, 1);
      load6 = 1'b1;
      cyc();
      load6 = 1'b0;
      for (int i = 0; i < q6.size(); i++) begin
        chk("w1_tx", tx6, q6[i]);
        chk("w1_busy", busy6, 1);
        chk("w1_done", done6, (i == q6.size() - 1));
        cyc();
      end
      chk("w1_idle_tx", tx6, 1);
      chk("w1_idle_busy", busy6, 0);
      chk("w1_idle_done", done6, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
